// File: rtl/ma_pkg.sv
// Shared FSM encoding and default sizing for the multi-channel moving-average scheduler.
package ma_pkg;
    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_WIN_LOG2 = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        READ   = 3'd2,
        UPDATE = 3'd3,
        OUT    = 3'd4,
        CLEAR  = 3'd5
    } state_e;

    // A full window of 2**win_log2 samples of data_w bits fits in this many bits.
    function automatic int sum_width(input int data_w, input int win_log2);
        return data_w + win_log2;
    endfunction
endpackage

// File: rtl/ma_channel_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic [NUM_CH-1:0] o_grant,
    output logic [CH_W-1:0]   o_idx,
    output logic              o_any
);
    int              w_cand;
    logic [CH_W-1:0] w_c;

    // Scan from the farthest offset to the nearest so the closest requester overwrites the rest.
    always_comb begin
        o_idx  = '0;
        w_cand = 0;
        w_c    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_cand = int'(i_ptr) + k;
            w_cand = (w_cand >= NUM_CH) ? (w_cand - NUM_CH) : w_cand;
            w_c    = CH_W'(w_cand);
            o_idx  = i_req[w_c] ? w_c : o_idx;
        end
        o_any   = |i_req;
        o_grant = o_any ? (NUM_CH'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/ma_channel_scheduler.sv
// Time-shared moving-average engine: one datapath, per-channel history/sum/pointer/fill state.
module ma_channel_scheduler
    import ma_pkg::*;
#(
    parameter  int NUM_CH   = DEF_NUM_CH,
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int WIN_LOG2 = DEF_WIN_LOG2,
    localparam int CH_W     = $clog2(NUM_CH),
    localparam int WIN      = 1 << WIN_LOG2,
    localparam int SUM_W    = sum_width(DATA_W, WIN_LOG2),
    localparam int CNT_W    = WIN_LOG2 + 1,
    localparam int ADDR_W   = CH_W + WIN_LOG2,
    localparam int DEPTH    = NUM_CH * WIN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic                     clr_valid,
    input  logic [CH_W-1:0]          clr_ch,
    output logic                     clr_ready,
    output logic                     avg_valid,
    input  logic                     avg_ready,
    output logic [DATA_W-1:0]        avg_data,
    output logic [CH_W-1:0]          avg_ch,
    output logic                     avg_warm
);
    state_e              r_state;
    state_e              w_next_state;

    logic [CH_W-1:0]     r_rr_ptr;
    logic [CH_W-1:0]     r_ch;
    logic [DATA_W-1:0]   r_new;
    logic [DATA_W-1:0]   r_old;
    logic [SUM_W-1:0]    r_sum  [NUM_CH];
    logic [WIN_LOG2-1:0] r_ptr  [NUM_CH];
    logic [CNT_W-1:0]    r_cnt  [NUM_CH];
    logic [DATA_W-1:0]   r_hist [DEPTH];

    logic [CH_W-1:0]     r_clr_ch;
    logic [WIN_LOG2-1:0] r_clr_idx;
    logic                r_clr_bad;

    logic [NUM_CH-1:0]   r_req_ready;
    logic                r_clr_ready;
    logic                r_avg_valid;
    logic [DATA_W-1:0]   r_avg_data;
    logic [CH_W-1:0]     r_avg_ch;
    logic                r_avg_warm;

    logic [NUM_CH-1:0]   w_grant;
    logic [CH_W-1:0]     w_gidx;
    logic                w_any;
    logic [CH_W-1:0]     w_rr_next;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic [SUM_W-1:0]    w_sum_new;
    logic [CNT_W-1:0]    w_cnt_new;
    logic                w_clr_bad_in;
    logic                w_clr_last;
    logic [NUM_CH-1:0]   w_req_ready_d;
    logic                w_clr_ready_d;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    assign w_rr_next    = (r_ch == CH_W'(NUM_CH - 1)) ? '0 : (r_ch + CH_W'(1));
    assign w_rd_addr    = {r_ch, r_ptr[r_ch]};
    assign w_sum_new    = r_sum[r_ch] - {{WIN_LOG2{1'b0}}, r_old} + {{WIN_LOG2{1'b0}}, r_new};
    assign w_cnt_new    = (r_cnt[r_ch] == CNT_W'(WIN)) ? r_cnt[r_ch] : (r_cnt[r_ch] + CNT_W'(1));
    assign w_clr_bad_in = ({1'b0, clr_ch} >= (CH_W + 1)'(NUM_CH));
    assign w_clr_last   = r_clr_bad || (r_clr_idx == WIN_LOG2'(WIN - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a pending flush always beats a pending sample in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (clr_valid) begin
                    w_next_state = CLEAR;
                end else if (w_any) begin
                    w_next_state = ARB;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ARB:     w_next_state = READ;
            READ:    w_next_state = UPDATE;
            UPDATE:  w_next_state = OUT;
            OUT:     w_next_state = avg_ready ? IDLE : OUT;
            CLEAR:   w_next_state = w_clr_last ? IDLE : CLEAR;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode: next values of the registered strobes, so they land in ARB / last CLEAR cycle.
    always_comb begin
        w_req_ready_d = '0;
        w_clr_ready_d = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready_d = (w_next_state == ARB) ? w_grant : '0;
                w_clr_ready_d = clr_valid && w_clr_bad_in;
            end
            CLEAR: begin
                w_req_ready_d = '0;
                w_clr_ready_d = !r_clr_bad && (r_clr_idx == WIN_LOG2'(WIN - 2));
            end
            default: begin
                w_req_ready_d = '0;
                w_clr_ready_d = 1'b0;
            end
        endcase
    end

    // Registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_ready <= '0;
            r_clr_ready <= 1'b0;
            r_avg_valid <= 1'b0;
            r_avg_data  <= '0;
            r_avg_ch    <= '0;
            r_avg_warm  <= 1'b0;
        end else begin
            r_req_ready <= w_req_ready_d;
            r_clr_ready <= w_clr_ready_d;
            if (r_state == UPDATE) begin
                r_avg_valid <= 1'b1;
                r_avg_data  <= w_sum_new[SUM_W-1:WIN_LOG2];
                r_avg_ch    <= r_ch;
                r_avg_warm  <= (w_cnt_new == CNT_W'(WIN));
            end else if ((r_state == OUT) && avg_ready) begin
                r_avg_valid <= 1'b0;
                r_avg_data  <= '0;
                r_avg_ch    <= '0;
                r_avg_warm  <= 1'b0;
            end
        end
    end

    // Sample/flush bookkeeping: grant capture, data latch, oldest-sample read, flush walk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_ch      <= '0;
            r_new     <= '0;
            r_old     <= '0;
            r_clr_ch  <= '0;
            r_clr_idx <= '0;
            r_clr_bad <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_next_state == CLEAR) begin
                        r_clr_ch  <= clr_ch;
                        r_clr_bad <= w_clr_bad_in;
                        r_clr_idx <= '0;
                    end else if (w_next_state == ARB) begin
                        r_ch <= w_gidx;
                    end
                end
                ARB: begin
                    r_new    <= req_data[r_ch*DATA_W +: DATA_W];
                    r_rr_ptr <= w_rr_next;
                end
                READ:  r_old     <= r_hist[w_rd_addr];
                CLEAR: r_clr_idx <= r_clr_idx + WIN_LOG2'(1);
                default: begin
                end
            endcase
        end
    end

    // Single write port shared between the sample update and the flush walk.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        case (r_state)
            UPDATE: begin
                w_we    = 1'b1;
                w_waddr = w_rd_addr;
                w_wdata = r_new;
            end
            CLEAR: begin
                w_we    = !r_clr_bad;
                w_waddr = {r_clr_ch, r_clr_idx};
                w_wdata = '0;
            end
            default: begin
                w_we    = 1'b0;
                w_waddr = '0;
                w_wdata = '0;
            end
        endcase
    end

    // History storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else if (w_we) begin
            r_hist[w_waddr] <= w_wdata;
        end
    end

    // Per-channel running sum, write pointer and fill count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_sum[i] <= '0;
                r_ptr[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else if (r_state == UPDATE) begin
            r_sum[r_ch] <= w_sum_new;
            r_ptr[r_ch] <= r_ptr[r_ch] + WIN_LOG2'(1);
            r_cnt[r_ch] <= w_cnt_new;
        end else if ((r_state == CLEAR) && !r_clr_bad && w_clr_last) begin
            r_sum[r_clr_ch] <= '0;
            r_ptr[r_clr_ch] <= '0;
            r_cnt[r_clr_ch] <= '0;
        end
    end

    assign req_ready = r_req_ready;
    assign clr_ready = r_clr_ready;
    assign avg_valid = r_avg_valid;
    assign avg_data  = r_avg_data;
    assign avg_ch    = r_avg_ch;
    assign avg_warm  = r_avg_warm;
endmodule

// File: tb/tb_ma_channel_scheduler.sv
// Directed scoreboard bench for ma_channel_scheduler (4 channels, 8-bit samples, window 4).
module tb_ma_channel_scheduler;
    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        clr_valid;
    logic [1:0]  clr_ch;
    logic        clr_ready;
    logic        avg_valid;
    logic        avg_ready;
    logic [7:0]  avg_data;
    logic [1:0]  avg_ch;
    logic        avg_warm;

    ma_channel_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr_valid (clr_valid),
        .clr_ch    (clr_ch),
        .clr_ready (clr_ready),
        .avg_valid (avg_valid),
        .avg_ready (avg_ready),
        .avg_data  (avg_data),
        .avg_ch    (avg_ch),
        .avg_warm  (avg_warm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ch;
        logic       warm;
        int         cyc;
    } exp_t;

    exp_t       sbq [$];
    logic [7:0] pend [4][$];
    logic [7:0] m_hist [4][4];
    int         m_sum [4];
    int         m_ptr [4];
    int         m_cnt [4];
    int         m_rr;
    int         cyc;
    int         n_pass;
    int         n_total;
    int         n_fail;
    logic [3:0] prev_valid;
    logic       new_res;
    logic       clr_pend;
    int         clr_exp_cyc;
    int         clr_target;
    logic       tb_avg_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]         = (pend[i].size() > 0);
            req_data[i*8 +: 8]   = (pend[i].size() > 0) ? pend[i][0] : 8'd0;
        end
        avg_ready = tb_avg_ready;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) m_hist[i][j] = 8'd0;
            m_sum[i] = 0;
            m_ptr[i] = 0;
            m_cnt[i] = 0;
            pend[i].delete();
        end
        m_rr       = 0;
        sbq.delete();
        prev_valid = 4'd0;
        new_res    = 1'b1;
        clr_pend   = 1'b0;
    endtask

    task automatic model_accept(input int g);
        exp_t e;
        logic [7:0] d;
        d = pend[g][0];
        m_sum[g] = m_sum[g] - int'(m_hist[g][m_ptr[g]]) + int'(d);
        m_hist[g][m_ptr[g]] = d;
        m_ptr[g] = (m_ptr[g] + 1) % 4;
        if (m_cnt[g] < 4) m_cnt[g]++;
        e.data = 8'(m_sum[g] / 4);
        e.ch   = 2'(g);
        e.warm = (m_cnt[g] == 4);
        e.cyc  = cyc + 3;
        sbq.push_back(e);
        m_rr = (g + 1) % 4;
    endtask

    function automatic int exp_grant(input logic [3:0] v);
        int c;
        for (int k = 0; k < 4; k++) begin
            c = (m_rr + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // One clock: observe at the falling edge, update stimulus just after the rising edge.
    task automatic tick();
        int         g;
        logic       took;
        logic       clr_done;
        logic [3:0] sel;
        logic [3:0] one_hot;
        g    = -1;
        took = 1'b0;
        @(negedge clk);
        cyc++;
        check("clr_ready", 32'(clr_ready), 32'(clr_pend && (cyc == clr_exp_cyc)));
        if (req_ready != 4'd0) begin
            g       = exp_grant(prev_valid);
            sel     = 4'b0001;
            one_hot = (g >= 0) ? (sel << g) : 4'd0;
            check("grant", 32'(req_ready), 32'(one_hot));
            check("grant_during_clear", 32'(clr_pend), 32'd0);
            if (g >= 0) begin
                if (pend[g].size() > 0) begin
                    model_accept(g);
                    took = 1'b1;
                end
            end
        end
        if (avg_valid) begin
            check("ready_while_out", 32'(req_ready), 32'd0);
            if (sbq.size() == 0) begin
                check("avg_spurious", 32'(avg_valid), 32'd0);
            end else begin
                if (new_res) begin
                    check("avg_latency", 32'(cyc), 32'(sbq[0].cyc));
                    new_res = 1'b0;
                end
                check("avg_result", 32'({avg_warm, avg_ch, avg_data}),
                      32'({sbq[0].warm, sbq[0].ch, sbq[0].data}));
                if (avg_ready) begin
                    void'(sbq.pop_front());
                    new_res = 1'b1;
                end
            end
        end
        prev_valid = req_valid;
        clr_done   = clr_pend && clr_ready;
        @(posedge clk);
        #1;
        if (took) void'(pend[g].pop_front());
        if (clr_done) begin
            clr_valid = 1'b0;
            clr_pend  = 1'b0;
            for (int j = 0; j < 4; j++) m_hist[clr_target][j] = 8'd0;
            m_sum[clr_target] = 0;
            m_ptr[clr_target] = 0;
            m_cnt[clr_target] = 0;
        end
        drive();
    endtask

    function automatic logic busy();
        logic b;
        b = (sbq.size() > 0) || clr_pend;
        for (int i = 0; i < 4; i++) b = b || (pend[i].size() > 0);
        return b;
    endfunction

    task automatic drain();
        int k;
        k = 0;
        while (busy() && (k < 300)) begin
            tick();
            k++;
        end
        check("drain_timeout", 32'(busy()), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_clr_ready"}, 32'(clr_ready), 32'd0);
        check({tag, "_avg_valid"}, 32'(avg_valid), 32'd0);
        check({tag, "_avg_bus"},   32'({avg_warm, avg_ch, avg_data}), 32'd0);
    endtask

    // Reset is raised just after a rising edge and must clear outputs without waiting for a clock.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_zero_outputs(tag);
        model_reset();
        clr_valid = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        n_fail       = 0;
        cyc          = 0;
        tb_avg_ready = 1'b1;
        clr_valid    = 1'b0;
        clr_ch       = 2'd0;
        clr_target   = 0;
        clr_exp_cyc  = 0;
        req_valid    = 4'd0;
        req_data     = 32'd0;
        avg_ready    = 1'b1;
        rst          = 1'b1;
        model_reset();
        drive();
        @(posedge clk);
        #1;
        do_reset("reset");

        // Warm-up on ch0, then one more sample to wrap the write pointer.
        pend[0].push_back(8'd40);
        pend[0].push_back(8'd80);
        pend[0].push_back(8'd120);
        pend[0].push_back(8'd160);
        drive();
        drain();
        pend[0].push_back(8'd200);
        drive();
        drain();

        // Every channel requesting at once; grants must rotate from ch0.
        do_reset("reset2");
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) pend[i].push_back(8'(4 * i + 4));
        end
        drive();
        drain();

        // Downstream stall with another request waiting behind it.
        tb_avg_ready = 1'b0;
        pend[3].push_back(8'd200);
        drive();
        repeat (5) tick();
        pend[0].push_back(8'd9);
        drive();
        repeat (10) tick();
        tb_avg_ready = 1'b1;
        drive();
        drain();

        // Flush and sample on the same channel at the same time: flush goes first.
        clr_valid   = 1'b1;
        clr_ch      = 2'd1;
        clr_target  = 1;
        clr_pend    = 1'b1;
        clr_exp_cyc = cyc + 5;
        pend[1].push_back(8'd100);
        drive();
        drain();

        // Reset in the middle of an update drops the sample.
        pend[3].push_back(8'd77);
        drive();
        for (int k = 0; (k < 20) && (sbq.size() == 0); k++) tick();
        check("t6_accept", 32'(sbq.size()), 32'd1);
        tick();
        do_reset("reset_mid");
        repeat (6) tick();
        pend[2].push_back(8'd255);
        drive();
        drain();
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
